// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package    : stopwatch_pkg                                       |
// | Description: Shared types and constants for the stopwatch front  |
// |              end (debounce FSM encoding, board timing defaults). |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package stopwatch_pkg;

  // Board oscillator frequency in Hz.
  localparam int BOARD_CLK_HZ = 100_000_000;

  // 10 ms of stability at the board clock before a change is accepted.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Debounce channel state. The *_PEND states are qualifying a change
  // that has been seen on the synchronised input but not yet accepted.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    RISE_PEND = 2'd1,
    STABLE_HI = 2'd2,
    FALL_PEND = 2'd3
  } db_state_t;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface  : input_conditioner_if                                |
// | Description: Raw board inputs and conditioned outputs of the     |
// |              stopwatch input conditioner.                        |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
interface input_conditioner_if;

  // Raw, asynchronous board inputs
  logic btn_reset_raw;
  logic btn_pause_raw;
  logic sw_adjust_raw;
  logic sw_select_raw;

  // Conditioned, clk-domain outputs
  logic reset_pulse;
  logic pause_pulse;
  logic pause_state;
  logic adjust_level;
  logic select_level;

  // Board / stimulus side: drives the raw inputs, observes the results.
  modport master (
    output btn_reset_raw,
    output btn_pause_raw,
    output sw_adjust_raw,
    output sw_select_raw,
    input  reset_pulse,
    input  pause_pulse,
    input  pause_state,
    input  adjust_level,
    input  select_level
  );

  // Conditioner side.
  modport slave (
    input  btn_reset_raw,
    input  btn_pause_raw,
    input  sw_adjust_raw,
    input  sw_select_raw,
    output reset_pulse,
    output pause_pulse,
    output pause_state,
    output adjust_level,
    output select_level
  );

endinterface : input_conditioner_if
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : debounce_channel                                    |
// | Description: 2-flop synchroniser followed by a counter-qualified |
// |              debounce FSM. Emits a registered level and a        |
// |              one-cycle pulse on each accepted rising edge.       |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module debounce_channel
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  // Terminal count: the pending state has seen DEBOUNCE_CYCLES stable
  // synchronised samples once the counter reaches this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta;
  logic             sync;
  db_state_t        state;
  db_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             pulse_next;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  // Debounce state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      level      <= level_next;
      rise_pulse <= pulse_next;
    end
  end

  // Next-state logic; the counter is cleared on every acceptance or
  // rejection so it can never pass CNT_LAST or wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    pulse_next = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync) begin
          state_next = RISE_PEND;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      RISE_PEND: begin
        if (!sync) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
          level_next = 1'b1;
          pulse_next = 1'b1;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync) begin
          state_next = FALL_PEND;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      FALL_PEND: begin
        if (sync) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
          level_next = 1'b0;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : input_conditioner                                   |
// | Description: Synchronises and debounces the stopwatch buttons    |
// |              and switches; owns the pause toggle flag.           |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module input_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input_conditioner_if.slave  bus
);

  localparam int NUM_CH    = 4;
  localparam int CH_RESET  = 0;
  localparam int CH_PAUSE  = 1;
  localparam int CH_ADJUST = 2;
  localparam int CH_SELECT = 3;

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] level_vec;
  logic [NUM_CH-1:0] rise_vec;
  logic              pause_state;

  assign raw_vec = {bus.sw_select_raw, bus.sw_adjust_raw,
                    bus.btn_pause_raw, bus.btn_reset_raw};

  // One identical conditioning channel per raw input.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (raw_vec[ch]),
      .level      (level_vec[ch]),
      .rise_pulse (rise_vec[ch])
    );
  end

  // Pause flag: a reset press clears it and beats a same-cycle pause press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_state <= 1'b0;
    end else if (rise_vec[CH_RESET]) begin
      pause_state <= 1'b0;
    end else if (rise_vec[CH_PAUSE]) begin
      pause_state <= ~pause_state;
    end
  end

  assign bus.reset_pulse  = rise_vec[CH_RESET];
  assign bus.pause_pulse  = rise_vec[CH_PAUSE];
  assign bus.pause_state  = pause_state;
  assign bus.adjust_level = level_vec[CH_ADJUST];
  assign bus.select_level = level_vec[CH_SELECT];

  // Buttons only expose their press pulse and switches only their level.
  logic unused_ch_outputs;
  assign unused_ch_outputs = ^{level_vec[CH_RESET], level_vec[CH_PAUSE],
                               rise_vec[CH_ADJUST], rise_vec[CH_SELECT]};

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : tb_input_conditioner                                |
// | Description: Self-checking bench for input_conditioner with a    |
// |              short debounce window.                              |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_input_conditioner;

  localparam int DC = 4;   // debounce cycles
  localparam int CW = 3;   // counter width

  // Edge index (0-based, counted from the first edge that samples a new
  // raw value) at which a qualified press appears on the outputs.
  localparam int PULSE_IDX = DC + 1;

  logic clk = 1'b0;
  logic rst_n;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // raw   = {select, adjust, pause, reset}
  // exp   = {reset_pulse, pause_pulse, pause_state, adjust_level, select_level}
  typedef struct {
    logic [3:0] raw;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] raw, input logic [4:0] exp, input int n);
    vec_t v;
    v.raw = raw;
    v.exp = exp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic set_raw(input logic [3:0] raw);
    {bus.sw_select_raw, bus.sw_adjust_raw, bus.btn_pause_raw, bus.btn_reset_raw} = raw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] exp);
    logic [4:0] act;
    act = {bus.reset_pulse, bus.pause_pulse, bus.pause_state,
           bus.adjust_level, bus.select_level};
    check({tag, ".reset_pulse"},  act[4], exp[4]);
    check({tag, ".pause_pulse"},  act[3], exp[3]);
    check({tag, ".pause_state"},  act[2], exp[2]);
    check({tag, ".adjust_level"}, act[1], exp[1]);
    check({tag, ".select_level"}, act[0], exp[0]);
  endtask

  // Hold a button pattern 10 cycles then release 10 cycles, checking the
  // pulse position and the pause flag before/after the pulse.
  task automatic press(input logic [3:0] raw, input logic st_before,
                       input logic st_after, input string tag);
    for (int i = 0; i < 10; i++) begin
      set_raw(raw);
      tick();
      check($sformatf("%s.hold%0d.pause_pulse", tag, i), bus.pause_pulse,
            (i == PULSE_IDX) && raw[1]);
      check($sformatf("%s.hold%0d.reset_pulse", tag, i), bus.reset_pulse,
            (i == PULSE_IDX) && raw[0]);
      check($sformatf("%s.hold%0d.pause_state", tag, i), bus.pause_state,
            (i > PULSE_IDX) ? st_after : st_before);
    end
    for (int i = 0; i < 10; i++) begin
      set_raw(4'b0000);
      tick();
      check($sformatf("%s.rel%0d.pause_pulse", tag, i), bus.pause_pulse, 1'b0);
      check($sformatf("%s.rel%0d.reset_pulse", tag, i), bus.reset_pulse, 1'b0);
      check($sformatf("%s.rel%0d.pause_state", tag, i), bus.pause_state, st_after);
    end
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] bpat;

    // Clean press, 20-cycle hold, release, then the two switches.
    add(4'b0010, 5'b00000, DC + 1);
    add(4'b0010, 5'b01000, 1);
    add(4'b0010, 5'b00100, 14);
    add(4'b0000, 5'b00100, 10);
    add(4'b0100, 5'b00100, DC + 1);
    add(4'b0100, 5'b00110, 4);
    add(4'b1100, 5'b00110, DC + 1);
    add(4'b1100, 5'b00111, 3);
    add(4'b0100, 5'b00111, DC + 1);
    add(4'b0100, 5'b00110, 3);

    // Reset state
    rst_n = 1'b0;
    set_raw(4'b0000);
    repeat (3) tick();
    check_outs("reset_hold", 5'b00000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      set_raw(vecs[i].raw);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Adjust switch: 3-cycle drop is rejected
    for (int i = 0; i < 3; i++) begin
      set_raw(4'b0000);
      tick();
      check($sformatf("adj_glitch%0d", i), bus.adjust_level, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      set_raw(4'b0100);
      tick();
      check($sformatf("adj_after_glitch%0d", i), bus.adjust_level, 1'b1);
    end
    // Sustained drop clears the level
    for (int i = 0; i < 10; i++) begin
      set_raw(4'b0000);
      tick();
      check($sformatf("adj_fall%0d", i), bus.adjust_level, (i < PULSE_IDX));
    end

    // Bounce rejection on pause: 1,0,1,1,0 then quiet
    bpat = 5'b01101;
    for (int i = 0; i < 12; i++) begin
      set_raw((i < 5) ? {2'b00, bpat[i], 1'b0} : 4'b0000);
      tick();
      check($sformatf("bounce%0d.pause_pulse", i), bus.pause_pulse, 1'b0);
      check($sformatf("bounce%0d.pause_state", i), bus.pause_state, 1'b1);
    end
    press(4'b0010, 1'b1, 1'b0, "after_bounce");

    // Toggle sequence 1,0,1
    press(4'b0010, 1'b0, 1'b1, "toggle1");
    press(4'b0010, 1'b1, 1'b0, "toggle2");
    press(4'b0010, 1'b0, 1'b1, "toggle3");

    // Reset and pause together: reset wins
    press(4'b0011, 1'b1, 1'b0, "priority");

    // Async reset mid-operation
    for (int i = 0; i < 10; i++) begin
      set_raw(4'b0110);
      tick();
    end
    check("pre_reset.pause_state", bus.pause_state, 1'b1);
    check("pre_reset.adjust_level", bus.adjust_level, 1'b1);
    set_raw(4'b1100);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 5'b00000);
    for (int i = 0; i < 4; i++) begin
      set_raw(4'($urandom));
      tick();
      check_outs($sformatf("in_reset%0d", i), 5'b00000);
    end

    // Button held through reset release counts as a fresh press
    set_raw(4'b0010);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs($sformatf("held_release%0d", i),
                 {1'b0, (i == PULSE_IDX), (i > PULSE_IDX), 2'b00});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_input_conditioner
`default_nettype wire
